// File: rtl/note_tone_gen_if.sv
// rtl/note_tone_gen_if.sv - key/octave inputs and speaker status bundle for note_tone_gen
interface note_tone_gen_if #(
  parameter int N_KEYS = 12,
  parameter int OCT_W  = 3
);
  localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] keys;
  logic [OCT_W-1:0]  octave;
  logic              speaker;
  logic              active;
  logic [IDX_W-1:0]  note_idx;
  logic              tone_edge;

  modport master (
    output keys,
    output octave,
    input  speaker,
    input  active,
    input  note_idx,
    input  tone_edge
  );

  modport slave (
    input  keys,
    input  octave,
    output speaker,
    output active,
    output note_idx,
    output tone_edge
  );
endinterface

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - priority-keyed square-wave tone generator with octave shift
// Optional post-release sustain is compiled in with NOTE_SUSTAIN_EN.
module note_tone_gen #(
  parameter int                     N_KEYS         = 12,
  parameter int                     DIV_W          = 20,
  // Default table: C4..B4 half-periods at a 50 MHz clock, key 0 = C4.
  parameter logic [N_KEYS*DIV_W-1:0] HALF_PERIODS  = {
    20'd50619, 20'd53629, 20'd56818, 20'd60196, 20'd63776, 20'd67568,
    20'd71586, 20'd75843, 20'd80354, 20'd85131, 20'd90194, 20'd95556
  },
  parameter int                     OCT_W          = 3,
  parameter int                     SUSTAIN_W      = 24,
  parameter int                     SUSTAIN_CYCLES = 2**20
) (
  input  logic          clk,
  input  logic          rst,
  note_tone_gen_if.slave bus
);

  localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  if (N_KEYS < 1 || DIV_W < 1 || SUSTAIN_CYCLES < 1 ||
      SUSTAIN_W < $clog2(SUSTAIN_CYCLES + 1)) begin : g_bad_params
    $error("note_tone_gen: inconsistent parameters");
  end

`ifdef NOTE_SUSTAIN_EN
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, SUSTAIN} state_t;
  localparam logic [SUSTAIN_W-1:0] SUS_LAST = SUSTAIN_W'(SUSTAIN_CYCLES - 1);
  logic [SUSTAIN_W-1:0] sus_cnt, sus_n;
`else
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
`endif

  state_t           state, state_n;
  logic [DIV_W-1:0] counter, counter_n;
  logic             speaker, speaker_n;
  logic             active;
  logic [IDX_W-1:0] note_idx, note_n;
  logic             tone_edge, edge_n;

  logic             pressed;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] key_sel;
  logic [DIV_W-1:0] tbl;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] d_m1;
  logic             wrap;

  assign pressed = |bus.keys;
  assign wrap    = (counter == '0);

  always_comb begin
    k = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (bus.keys[i]) k = IDX_W'(i);
    end
  end

  // With keys released the reload keeps following the note already sounding.
  assign key_sel = pressed ? k : note_idx;

  always_comb begin
    tbl = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (key_sel == IDX_W'(i)) tbl = HALF_PERIODS[i*DIV_W +: DIV_W];
    end
  end

  assign shifted = tbl >> bus.octave;
  assign d_m1    = (shifted == '0) ? '0 : shifted - DIV_W'(1);

  always_comb begin
    state_n   = state;
    counter_n = counter;
    speaker_n = speaker;
    note_n    = note_idx;
    edge_n    = 1'b0;
`ifdef NOTE_SUSTAIN_EN
    sus_n     = sus_cnt;
`endif
    case (state)
      IDLE: begin
        if (pressed) begin
          counter_n = d_m1;
          note_n    = k;
          state_n   = PLAY;
        end
      end

      PLAY: begin
        if (wrap) begin
          speaker_n = ~speaker;
          edge_n    = 1'b1;
          counter_n = d_m1;
          if (pressed) note_n = k;
        end else begin
          counter_n = counter - DIV_W'(1);
        end
        if (!pressed) begin
`ifdef NOTE_SUSTAIN_EN
          state_n = SUSTAIN;
          sus_n   = '0;
`else
          // The toggle above has already happened; decide on its result.
          if (!speaker_n) begin
            state_n   = IDLE;
            counter_n = '0;
          end else begin
            state_n = DRAIN;
          end
`endif
        end
      end

`ifdef NOTE_SUSTAIN_EN
      SUSTAIN: begin
        if (wrap) begin
          speaker_n = ~speaker;
          edge_n    = 1'b1;
          counter_n = d_m1;
          if (pressed) note_n = k;
        end else begin
          counter_n = counter - DIV_W'(1);
        end
        if (pressed) begin
          state_n = PLAY;
          sus_n   = '0;
        end else if (sus_cnt == SUS_LAST) begin
          if (!speaker_n) begin
            state_n   = IDLE;
            counter_n = '0;
          end else begin
            state_n = DRAIN;
          end
        end else begin
          sus_n = sus_cnt + SUSTAIN_W'(1);
        end
      end
`endif

      DRAIN: begin
        if (wrap) begin
          speaker_n = 1'b0;
          edge_n    = 1'b1;
          if (pressed) begin
            counter_n = d_m1;
            note_n    = k;
            state_n   = PLAY;
          end else begin
            counter_n = '0;
            state_n   = IDLE;
          end
        end else begin
          counter_n = counter - DIV_W'(1);
          if (pressed) state_n = PLAY;
        end
      end

      default: begin
        state_n   = IDLE;
        counter_n = '0;
        speaker_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      speaker   <= 1'b0;
      active    <= 1'b0;
      note_idx  <= '0;
      tone_edge <= 1'b0;
`ifdef NOTE_SUSTAIN_EN
      sus_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      speaker   <= speaker_n;
      active    <= (state_n != IDLE);
      note_idx  <= note_n;
      tone_edge <= edge_n;
`ifdef NOTE_SUSTAIN_EN
      sus_cnt   <= sus_n;
`endif
    end
  end

  assign bus.speaker   = speaker;
  assign bus.active    = active;
  assign bus.note_idx  = note_idx;
  assign bus.tone_edge = tone_edge;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - self-checking bench for note_tone_gen (4 keys, table 8/6/4/0)
module tb_note_tone_gen;
  localparam int NK = 4;
  localparam int DW = 8;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_tone_gen_if #(.N_KEYS(NK), .OCT_W(OW)) tb_if();

  note_tone_gen #(
    .N_KEYS(NK),
    .DIV_W(DW),
    .HALF_PERIODS({8'd0, 8'd4, 8'd6, 8'd8}),
    .OCT_W(OW),
    .SUSTAIN_W(24),
    .SUSTAIN_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(tb_if.slave)
  );

  typedef struct {
    int   c;
    logic spk;
  } edge_t;

  typedef struct {
    logic [3:0] keys;
    logic [2:0] oct;
    int         d;
    int         idx;
  } vec_t;

  edge_t sb[$];
  edge_t mon_e;
  vec_t  vecs[10];
  int    cyc = 0;
  int    vec_n = 0;
  int    err_n = 0;
  logic  exp_spk = 1'b0;
  int    m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vec_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic spk);
    edge_t e;
    e.c   = c;
    e.spk = spk;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_speaker"}, int'(tb_if.speaker), 0);
    chk({tag, "_active"}, int'(tb_if.active), 0);
    chk({tag, "_tone_edge"}, int'(tb_if.tone_edge), 0);
    chk({tag, "_note_idx"}, int'(tb_if.note_idx), 0);
  endtask

  // Called on a falling edge; reset is raised between edges to show it acts asynchronously.
  task automatic do_reset();
    #2;
    chk("pending_edges", sb.size(), 0);
    sb.delete();
    rst = 1'b1;
    exp_spk = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tb_if.keys   = '0;
    tb_if.octave = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard consumer: every tone_edge must match the next scheduled toggle.
  always @(negedge clk) begin
    if (!rst) begin
      if (tb_if.tone_edge) begin
        if (sb.size() == 0) begin
          chk("unexpected_edge", cyc, -1);
        end else begin
          mon_e = sb.pop_front();
          chk("edge_cycle", cyc, mon_e.c);
          chk("edge_level", int'(tb_if.speaker), int'(mon_e.spk));
          exp_spk = mon_e.spk;
        end
      end else begin
        chk("speaker_hold", int'(tb_if.speaker), int'(exp_spk));
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0001, 3'd0, 8, 0};
    vecs[1] = '{4'b0010, 3'd0, 6, 1};
    vecs[2] = '{4'b0100, 3'd0, 4, 2};
    vecs[3] = '{4'b1000, 3'd0, 1, 3};
    vecs[4] = '{4'b0001, 3'd2, 2, 0};
    vecs[5] = '{4'b0110, 3'd0, 6, 1};
    vecs[6] = '{4'b0001, 3'd1, 4, 0};
    vecs[7] = '{4'b0100, 3'd3, 1, 2};
    vecs[8] = '{4'b1111, 3'd7, 1, 0};
    vecs[9] = '{4'b0010, 3'd1, 3, 1};

    tb_if.keys   = '0;
    tb_if.octave = '0;

    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("in_reset");
    end
    #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_active", int'(tb_if.active), 0);
      chk("idle_tone_edge", int'(tb_if.tone_edge), 0);
    end

    for (int i = 0; i < 10; i++) begin
      m = cyc;
      tb_if.keys   = vecs[i].keys;
      tb_if.octave = vecs[i].oct;
      for (int j = 1; j <= 4; j++) push(m + 1 + vecs[i].d * j, logic'(j % 2));
      at_cyc(m + 2);
      chk("vec_active", int'(tb_if.active), 1);
      chk("vec_note_idx", int'(tb_if.note_idx), vecs[i].idx);
      at_cyc(m + 1 + vecs[i].d * 4);
      do_reset();
    end

    // Note change mid half-period takes effect only at the next reload.
    m = cyc;
    tb_if.keys = 4'b0001;
    push(m + 9, 1'b1);
    push(m + 17, 1'b0);
    push(m + 23, 1'b1);
    push(m + 29, 1'b0);
    at_cyc(m + 12);
    tb_if.keys = 4'b0011;
    at_cyc(m + 14);
    tb_if.keys = 4'b0010;
    at_cyc(m + 16);
    chk("switch_idx_before", int'(tb_if.note_idx), 0);
    at_cyc(m + 18);
    chk("switch_idx_after", int'(tb_if.note_idx), 1);
    at_cyc(m + 29);
    do_reset();

`ifndef NOTE_SUSTAIN_EN
    // Release with speaker high drains to the scheduled falling edge.
    m = cyc;
    tb_if.keys = 4'b0001;
    push(m + 9, 1'b1);
    push(m + 17, 1'b0);
    at_cyc(m + 12);
    tb_if.keys = '0;
    at_cyc(m + 16);
    chk("drain_active", int'(tb_if.active), 1);
    at_cyc(m + 17);
    chk("drain_done_active", int'(tb_if.active), 0);

    // Re-press during drain keeps the running half-period.
    at_cyc(m + 20);
    m = cyc;
    tb_if.keys = 4'b0001;
    push(m + 9, 1'b1);
    push(m + 17, 1'b0);
    push(m + 25, 1'b1);
    push(m + 33, 1'b0);
    at_cyc(m + 11);
    tb_if.keys = '0;
    at_cyc(m + 13);
    chk("repress_drain_active", int'(tb_if.active), 1);
    tb_if.keys = 4'b0001;
    at_cyc(m + 33);
    tb_if.keys = '0;
    at_cyc(m + 35);
    chk("release_low_idle", int'(tb_if.active), 0);

    // Release coinciding with a toggle at d=1: toggle wins, then drain.
    at_cyc(m + 38);
    m = cyc;
    tb_if.keys = 4'b1000;
    push(m + 2, 1'b1);
    push(m + 3, 1'b0);
    push(m + 4, 1'b1);
    push(m + 5, 1'b0);
    at_cyc(m + 3);
    tb_if.keys = '0;
    at_cyc(m + 4);
    chk("coincide_active", int'(tb_if.active), 1);
    at_cyc(m + 5);
    chk("coincide_idle", int'(tb_if.active), 0);
    at_cyc(m + 8);
`else
    // Sustain keeps the tone 20 cycles past release, then drains.
    m = cyc;
    tb_if.keys = 4'b0001;
    push(m + 9, 1'b1);
    push(m + 17, 1'b0);
    push(m + 25, 1'b1);
    push(m + 33, 1'b0);
    at_cyc(m + 10);
    tb_if.keys = '0;
    at_cyc(m + 32);
    chk("sustain_active", int'(tb_if.active), 1);
    at_cyc(m + 34);
    chk("sustain_done", int'(tb_if.active), 0);
    at_cyc(m + 36);
`endif

    // Reset while the speaker is high.
    m = cyc;
    tb_if.keys = 4'b0001;
    push(m + 9, 1'b1);
    at_cyc(m + 11);
    chk("pre_reset_speaker", int'(tb_if.speaker), 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
